// File: rtl/mem_stage.sv
// mem_stage: load alignment/extension, data_ok wait FSM and MEM->WB regs.
// Buffers a returned word across a freeze and drops flush-orphaned responses.
module mem_stage #(
  parameter int MMOP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_flush_i,
  input  logic              mem_stall_i,
  input  logic              mem_wren_i,
  input  logic [4:0]        mem_waddr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [31:0]       mem_inst_i,
  input  logic              mem_inslot_i,
  input  logic [31:0]       mem_pc_i,
  input  logic              mem_nofwd_i,
  input  logic [MMOP_W-1:0] mem_memop_i,
  input  logic [1:0]        mem_memaddr_low_i,
  input  logic [31:0]       data_sram_rdata_i,
  input  logic              data_sram_dataok_i,
  output logic              mem_wren_o,
  output logic [4:0]        mem_waddr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [31:0]       mem_inst_o,
  output logic              mem_inslot_o,
  output logic [31:0]       mem_pc_o,
  output logic              mem_stallreq_o,
  output logic [31:0]       mem_wdata_bp_o,
  output logic              mem_bpvalid_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t      state;
  logic [31:0] buf_q;
  logic [31:0] raw;
  logic [31:0] result;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        access;
  logic        dok;

  assign access = |mem_memop_i;
  assign dok    = data_sram_dataok_i;

  assign mem_stallreq_o = access && !dok && !mem_flush_i &&
                          state != HOLD && state != DROP;

  assign raw  = (state == HOLD) ? buf_q : data_sram_rdata_i;
  assign bsel = raw[{mem_memaddr_low_i, 3'b000} +: 8];
  assign hsel = mem_memaddr_low_i[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    result = mem_wdata_i;
    unique case (1'b1)
      mem_memop_i[0]: result = {{24{bsel[7]}}, bsel};
      mem_memop_i[1]: result = {24'd0, bsel};
      mem_memop_i[2]: result = {{16{hsel[15]}}, hsel};
      mem_memop_i[3]: result = {16'd0, hsel};
      mem_memop_i[4]: result = raw;
      default: ;
    endcase
  end

  assign mem_wdata_bp_o = result;
  assign mem_bpvalid_o  = mem_wren_i && !mem_stallreq_o && !mem_nofwd_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      buf_q <= '0;
    end else if (mem_flush_i) begin
      state <= (state == WAIT) ? DROP : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (access && !dok) begin
            state <= WAIT;
          end else if (access && mem_stall_i) begin
            state <= HOLD;
            buf_q <= data_sram_rdata_i;
          end
        end
        WAIT: begin
          if (dok && mem_stall_i) begin
            state <= HOLD;
            buf_q <= data_sram_rdata_i;
          end else if (dok) begin
            state <= IDLE;
          end
        end
        HOLD: if (!mem_stall_i) state <= IDLE;
        DROP: if (dok) state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wren_o   <= 1'b0;
      mem_waddr_o  <= '0;
      mem_wdata_o  <= '0;
      mem_inst_o   <= '0;
      mem_inslot_o <= 1'b0;
      mem_pc_o     <= '0;
    end else if (mem_flush_i || mem_stallreq_o) begin
      mem_wren_o   <= 1'b0;
      mem_waddr_o  <= '0;
      mem_wdata_o  <= '0;
      mem_inst_o   <= '0;
      mem_inslot_o <= 1'b0;
      mem_pc_o     <= '0;
    end else if (!mem_stall_i) begin
      mem_wren_o   <= mem_wren_i;
      mem_waddr_o  <= mem_waddr_i;
      mem_wdata_o  <= result;
      mem_inst_o   <= mem_inst_i;
      mem_inslot_o <= mem_inslot_i;
      mem_pc_o     <= mem_pc_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus random traffic checked
// against a flag-based behavioural model of the MEM stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, stall, wren, inslot, nofwd, dataok;
  logic [4:0]  waddr;
  logic [31:0] wdata, inst, pc, rdata;
  logic [7:0]  memop;
  logic [1:0]  low;
  logic        o_wren, o_inslot, o_sreq, o_bpv;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata, o_inst, o_pc, o_bp;

  int vectors = 0;
  int miscompares = 0;

  // model: at most one of waiting / held / orphan is set
  bit          waiting, held, orphan;
  logic [31:0] hold_word;
  logic        e_wren, e_inslot;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata, e_inst, e_pc;

  mem_stage #(.MMOP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_flush_i(flush), .mem_stall_i(stall),
    .mem_wren_i(wren), .mem_waddr_i(waddr),
    .mem_wdata_i(wdata), .mem_inst_i(inst),
    .mem_inslot_i(inslot), .mem_pc_i(pc),
    .mem_nofwd_i(nofwd), .mem_memop_i(memop),
    .mem_memaddr_low_i(low),
    .data_sram_rdata_i(rdata),
    .data_sram_dataok_i(dataok),
    .mem_wren_o(o_wren), .mem_waddr_o(o_waddr),
    .mem_wdata_o(o_wdata), .mem_inst_o(o_inst),
    .mem_inslot_o(o_inslot), .mem_pc_o(o_pc),
    .mem_stallreq_o(o_sreq),
    .mem_wdata_bp_o(o_bp), .mem_bpvalid_o(o_bpv)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1);
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [31:0] extend(
    logic [7:0] op, logic [1:0] lo,
    logic [31:0] r, logic [31:0] alu);
    logic [31:0] b, h;
    b = (r >> (8 * lo)) & 32'hFF;
    h = (r >> (16 * lo[1])) & 32'hFFFF;
    if (op[0]) return (b ^ 32'h80) - 32'h80;
    if (op[1]) return b;
    if (op[2]) return (h ^ 32'h8000) - 32'h8000;
    if (op[3]) return h;
    if (op[4]) return r;
    return alu;
  endfunction

  task automatic model_reset();
    waiting = 0; held = 0; orphan = 0;
    hold_word = '0;
    e_wren = 0; e_waddr = '0; e_wdata = '0;
    e_inst = '0; e_inslot = 0; e_pc = '0;
  endtask

  task automatic idle_inputs();
    flush = 0; stall = 0; wren = 0; waddr = '0;
    wdata = '0; inst = '0; inslot = 0; pc = '0;
    nofwd = 0; memop = '0; low = '0;
    rdata = '0; dataok = 0;
  endtask

  // check this cycle at negedge, then advance model across the edge
  task automatic step();
    bit acc, sreq, bpv, resp, bubble;
    logic [31:0] res;
    bit n_wait, n_held, n_orph;
    logic [31:0] n_word;
    @(negedge clk);
    acc  = |memop;
    sreq = acc && !held && !orphan && !dataok && !flush;
    res  = extend(memop, low, held ? hold_word : rdata, wdata);
    bpv  = wren && !sreq && !nofwd;
    chk("stallreq", 32'(o_sreq), 32'(sreq));
    chk("bp_data", o_bp, res);
    chk("bpvalid", 32'(o_bpv), 32'(bpv));
    chk("wb_wren", 32'(o_wren), 32'(e_wren));
    chk("wb_waddr", 32'(o_waddr), 32'(e_waddr));
    chk("wb_wdata", o_wdata, e_wdata);
    chk("wb_inst", o_inst, e_inst);
    chk("wb_inslot", 32'(o_inslot), 32'(e_inslot));
    chk("wb_pc", o_pc, e_pc);
    n_wait = waiting; n_held = held;
    n_orph = orphan; n_word = hold_word;
    if (flush) begin
      n_orph = waiting; n_wait = 0; n_held = 0;
    end else if (held) begin
      if (!stall) n_held = 0;
    end else if (orphan) begin
      if (dataok) n_orph = 0;
    end else begin
      resp = dataok && (waiting || acc);
      if (resp) begin
        n_wait = 0;
        if (stall) begin
          n_held = 1; n_word = rdata;
        end
      end else if (acc) begin
        n_wait = 1;
      end
    end
    bubble = flush || sreq;
    @(posedge clk);
    #1;
    waiting = n_wait; held = n_held;
    orphan = n_orph; hold_word = n_word;
    if (bubble) begin
      e_wren = 0; e_waddr = '0; e_wdata = '0;
      e_inst = '0; e_inslot = 0; e_pc = '0;
    end else if (!stall) begin
      e_wren = wren; e_waddr = waddr; e_wdata = res;
      e_inst = inst; e_inslot = inslot; e_pc = pc;
    end
  endtask

  task automatic chk_regs_zero(string n);
    chk({n, "_wren"}, 32'(o_wren), 32'd0);
    chk({n, "_wdata"}, o_wdata, 32'd0);
    chk({n, "_pc"}, o_pc, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    #1;
    chk_regs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // 1: lb, zero-wait
    memop = 8'h01; low = 2'b11; rdata = 32'h80FF_1234;
    dataok = 1; wren = 1; waddr = 5'd4; pc = 32'h100;
    #1 chk("t1_sreq", 32'(o_sreq), 32'd0);
    step();
    chk("t1_wdata", o_wdata, 32'hFFFF_FF80);
    chk("t1_wren", 32'(o_wren), 32'd1);

    // 2: lhu, dataok 3 cycles late
    idle_inputs();
    memop = 8'h08; low = 2'b10; wren = 1; waddr = 5'd7;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t2_sreq", 32'(o_sreq), 32'd1);
      step();
      chk("t2_bubble", 32'(o_wren), 32'd0);
    end
    stall = 0; dataok = 1; rdata = 32'h8001_0000;
    step();
    chk("t2_wdata", o_wdata, 32'h0000_8001);

    // 3: lw returned while frozen
    idle_inputs();
    memop = 8'h10; wren = 1; waddr = 5'd9;
    dataok = 1; stall = 1; rdata = 32'hDEAD_BEEF;
    step();
    dataok = 0; rdata = '0;
    repeat (2) step();
    stall = 0;
    step();
    chk("t3_wdata", o_wdata, 32'hDEAD_BEEF);

    // 4: flush during WAIT, stale dataok dropped
    idle_inputs();
    memop = 8'h10; wren = 1; stall = 1;
    step();
    flush = 1; stall = 0;
    step();
    chk("t4_bubble", 32'(o_wren), 32'd0);
    idle_inputs();
    wren = 1; waddr = 5'd2; wdata = 32'd5;
    dataok = 1; rdata = 32'hBAD0_BAD0;
    step();
    chk("t4_wdata", o_wdata, 32'd5);
    chk("t4_wren", 32'(o_wren), 32'd1);

    // 5: sw, dataok one cycle late
    idle_inputs();
    memop = 8'h80; wdata = 32'h0000_1234; stall = 1;
    #1 chk("t5_sreq", 32'(o_sreq), 32'd1);
    step();
    dataok = 1; stall = 0;
    step();
    chk("t5_wren", 32'(o_wren), 32'd0);
    chk("t5_wdata", o_wdata, 32'h0000_1234);

    // 6: async reset while waiting
    idle_inputs();
    wren = 1; waddr = 5'd3; wdata = 32'h99;
    step();
    memop = 8'h10; stall = 1; wren = 1;
    step();
    rst_n = 0;
    #1;
    chk_regs_zero("t6_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    idle_inputs();
    dataok = 1;
    step();
    dataok = 0; wren = 1; waddr = 5'd6; wdata = 32'h77;
    step();
    chk("t6_wdata", o_wdata, 32'h77);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 11);
      memop = (r < 8) ? 8'(1 << r) : 8'h00;
      low = 2'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      dataok = ($urandom_range(0, 2) == 0);
      rdata = $urandom;
      wdata = $urandom;
      wren = 1'($urandom);
      nofwd = ($urandom_range(0, 5) == 0);
      waddr = 5'($urandom);
      inst = $urandom;
      inslot = 1'($urandom);
      pc = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
